wash_ctrl_param: RTL and testbench

Parametrised washing-machine sequencer, the next generation of the team's fixed-sequence wash FSM. It runs a full program: fill, detergent, wash, then a runtime-selectable number of rinse cycles, drain, and spin. It has internal wash/rinse/spin timers, pause/resume, and a door-open fault path. It sits between the appliance sensor inputs and the valve/motor drivers.

---
 rtl/wash_ctrl_param.sv | 198 +++++++++++++++++++
 tb/tb_wash_ctrl_param.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wash_ctrl_param.sv
// Parametrised washing-machine sequencer: fill, detergent, wash, N rinses, drain, spin.
// Pause freezes state and timer; opening the door while locked forces a fault state.
module wash_ctrl_param #(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned WASH_CYCLES  = 1000,
    parameter int unsigned RINSE_CYCLES = 500,
    parameter int unsigned SPIN_CYCLES  = 800,
    parameter int unsigned RINSE_W      = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               door_closed,
    input  logic               filled,
    input  logic               drained,
    input  logic               detergent_ok,
    input  logic               pause,
    input  logic [RINSE_W-1:0] num_rinses,
    output logic               door_lock,
    output logic               fill_valve,
    output logic               detergent_valve,
    output logic               drain_valve,
    output logic               motor_on,
    output logic               motor_fast,
    output logic               busy,
    output logic               done,
    output logic               fault,
    output logic [3:0]         state,
    output logic [RINSE_W-1:0] rinses_left
);

    localparam logic [CNT_W-1:0] WASH_LOAD  = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RINSE_LOAD = CNT_W'(RINSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPIN_LOAD  = CNT_W'(SPIN_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_FILL      = 4'd1,
        S_DETERGENT = 4'd2,
        S_AGITATE   = 4'd3,
        S_DRAIN     = 4'd4,
        S_SPIN      = 4'd5,
        S_DONE      = 4'd6,
        S_FAULT     = 4'd7
    } state_t;

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   timer_q;
    logic [CNT_W-1:0]   timer_d;
    logic               phase_q;
    logic               phase_d;
    logic [RINSE_W-1:0] rinses_d;
    logic               running;

    logic               door_lock_d;
    logic               fill_valve_d;
    logic               detergent_valve_d;
    logic               drain_valve_d;
    logic               motor_on_d;
    logic               motor_fast_d;
    logic               busy_d;
    logic               done_d;
    logic               fault_d;
    logic               run_d;
    logic               gate_d;

    assign running = (state_q >= S_FILL) && (state_q <= S_SPIN);
    assign state   = state_q;

    // State register plus registered output drivers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q         <= S_IDLE;
            timer_q         <= '0;
            phase_q         <= 1'b0;
            rinses_left     <= '0;
            door_lock       <= 1'b0;
            fill_valve      <= 1'b0;
            detergent_valve <= 1'b0;
            drain_valve     <= 1'b0;
            motor_on        <= 1'b0;
            motor_fast      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            fault           <= 1'b0;
        end else begin
            state_q         <= state_d;
            timer_q         <= timer_d;
            phase_q         <= phase_d;
            rinses_left     <= rinses_d;
            door_lock       <= door_lock_d;
            fill_valve      <= fill_valve_d;
            detergent_valve <= detergent_valve_d;
            drain_valve     <= drain_valve_d;
            motor_on        <= motor_on_d;
            motor_fast      <= motor_fast_d;
            busy            <= busy_d;
            done            <= done_d;
            fault           <= fault_d;
        end
    end

    // Next-state logic: door fault beats pause, pause beats normal sequencing
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        phase_d  = phase_q;
        rinses_d = rinses_left;
        if (running && !door_closed) begin
            state_d = S_FAULT;
        end else if (running && pause) begin
            state_d = state_q;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start && door_closed) begin
                        state_d  = S_FILL;
                        phase_d  = 1'b0;
                        rinses_d = num_rinses;
                    end
                end
                S_FILL: begin
                    if (filled) begin
                        if (phase_q) begin
                            state_d = S_AGITATE;
                            timer_d = RINSE_LOAD;
                        end else begin
                            state_d = S_DETERGENT;
                        end
                    end
                end
                S_DETERGENT: begin
                    if (detergent_ok) begin
                        state_d = S_AGITATE;
                        timer_d = WASH_LOAD;
                    end
                end
                S_AGITATE: begin
                    if (timer_q == '0) begin
                        state_d = S_DRAIN;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                S_DRAIN: begin
                    if (drained) begin
                        if (rinses_left != '0) begin
                            state_d  = S_FILL;
                            rinses_d = rinses_left - RINSE_W'(1);
                            phase_d  = 1'b1;
                        end else begin
                            state_d = S_SPIN;
                            timer_d = SPIN_LOAD;
                        end
                    end
                end
                S_SPIN: begin
                    if (timer_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        timer_d = timer_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (!start) begin
                        state_d = S_IDLE;
                    end
                end
                S_FAULT: begin
                    if (drained && !start) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Output decode of the upcoming state; pause silences valves and motor
    always_comb begin
        run_d             = (state_d >= S_FILL) && (state_d <= S_SPIN);
        gate_d            = run_d && pause;
        door_lock_d       = run_d;
        fill_valve_d      = (state_d == S_FILL) && !gate_d;
        detergent_valve_d = (state_d == S_DETERGENT) && !gate_d;
        drain_valve_d     = (((state_d == S_DRAIN) || (state_d == S_SPIN)) && !gate_d)
                            || (state_d == S_FAULT);
        motor_on_d        = (state_d == S_AGITATE) && !gate_d;
        motor_fast_d      = (state_d == S_SPIN) && !gate_d;
        busy_d            = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d            = (state_d == S_DONE);
        fault_d           = (state_d == S_FAULT);
    end

endmodule

// File: tb/tb_wash_ctrl_param.sv
// Bench for wash_ctrl_param: directed scenarios plus randomized programs,
// checked against a program-level reference model of the wash sequence.
module tb_wash_ctrl_param;

    localparam int unsigned CNT_W   = 16;
    localparam int unsigned WASH    = 1000;
    localparam int unsigned RINSE   = 500;
    localparam int unsigned SPIN    = 800;
    localparam int unsigned RINSE_W = 2;

    logic               clk;
    logic               rst;
    logic               start;
    logic               door_closed;
    logic               filled;
    logic               drained;
    logic               detergent_ok;
    logic               pause;
    logic [RINSE_W-1:0] num_rinses;
    logic               door_lock;
    logic               fill_valve;
    logic               detergent_valve;
    logic               drain_valve;
    logic               motor_on;
    logic               motor_fast;
    logic               busy;
    logic               done;
    logic               fault;
    logic [3:0]         state;
    logic [RINSE_W-1:0] rinses_left;

    int checks = 0;
    int errors = 0;
    bit hold_drain = 0;

    wash_ctrl_param #(
        .CNT_W(CNT_W), .WASH_CYCLES(WASH), .RINSE_CYCLES(RINSE),
        .SPIN_CYCLES(SPIN), .RINSE_W(RINSE_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .door_closed(door_closed),
        .filled(filled), .drained(drained), .detergent_ok(detergent_ok),
        .pause(pause), .num_rinses(num_rinses), .door_lock(door_lock),
        .fill_valve(fill_valve), .detergent_valve(detergent_valve),
        .drain_valve(drain_valve), .motor_on(motor_on), .motor_fast(motor_fast),
        .busy(busy), .done(done), .fault(fault), .state(state),
        .rinses_left(rinses_left)
    );

    logic [14:0] dut_vec;
    assign dut_vec = {door_lock, fill_valve, detergent_valve, drain_valve, motor_on,
                      motor_fast, busy, done, fault, state, rinses_left};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: program phase, elapsed run time in the timed phase, rinses owed
    int         m_state   = 0;
    int         m_elapsed = 0;
    int         m_dur     = 0;
    int         m_rinses  = 0;
    bit         m_rinse   = 0;
    int         m_ns      = 0;
    logic [8:0] m_out     = '0;

    function automatic logic [8:0] model_out(int s, logic p);
        bit run;
        bit g;
        run = (s >= 1) && (s <= 5);
        g   = run && p;
        return {run, (s == 1) && !g, (s == 2) && !g, (((s == 4) || (s == 5)) && !g) || (s == 7),
                (s == 3) && !g, (s == 5) && !g, (s != 0) && (s != 6), s == 6, s == 7};
    endfunction

    function automatic logic [14:0] exp_vec();
        return {m_out, 4'(m_state), RINSE_W'(m_rinses)};
    endfunction

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                m_state = 0; m_elapsed = 0; m_dur = 0; m_rinses = 0; m_rinse = 0; m_out = '0;
            end else begin
                m_ns = m_state;
                if (m_state >= 1 && m_state <= 5 && !door_closed) begin
                    m_ns = 7;
                end else if (!(m_state >= 1 && m_state <= 5 && pause)) begin
                    case (m_state)
                        0: if (start && door_closed) begin
                            m_ns = 1; m_rinses = int'(num_rinses); m_rinse = 0;
                        end
                        1: if (filled) begin
                            if (m_rinse) begin m_ns = 3; m_dur = RINSE; m_elapsed = 0; end
                            else m_ns = 2;
                        end
                        2: if (detergent_ok) begin m_ns = 3; m_dur = WASH; m_elapsed = 0; end
                        3, 5: begin
                            m_elapsed++;
                            if (m_elapsed == m_dur) m_ns = m_state + 1;
                        end
                        4: if (drained) begin
                            if (m_rinses > 0) begin m_rinses--; m_rinse = 1; m_ns = 1; end
                            else begin m_ns = 5; m_dur = SPIN; m_elapsed = 0; end
                        end
                        6: if (!start) m_ns = 0;
                        7: if (drained && !start) m_ns = 0;
                        default: m_ns = 0;
                    endcase
                end
                m_out   = model_out(m_ns, pause);
                m_state = m_ns;
            end
        end
    end

    // Appliance stand-in: each sensor answers its request, promptly or after random delay
    task automatic drive_plant(input bit rnd);
        filled       = (m_state == 1) && (!rnd || $urandom_range(0, 2) == 0);
        detergent_ok = (m_state == 2) && (!rnd || $urandom_range(0, 2) == 0);
        drained      = !hold_drain && (m_state == 4 || m_state == 7)
                       && (!rnd || $urandom_range(0, 2) == 0);
    endtask

    task automatic run_out();
        bit fin = 0;
        start = 1'b0;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge clk);
            if (m_state == 0) fin = 1;
            drive_plant(0);
        end
        if (!fin) begin
            errors++;
            $display("FAIL run_out timeout: state %0d, required 0", state);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (dut_vec !== 15'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h required %h", dut_vec, 15'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_release: got %h required %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_door_idle();
        door_closed = 1'b0;
        start       = 1'b1;
        repeat (5) begin
            @(negedge clk);
            checks++;
            if ({state, door_lock, busy} !== 6'd0 || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL door_open_idle: got %h required %h", dut_vec, exp_vec());
            end
        end
        start       = 1'b0;
        door_closed = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int seq[$];
        int exp_seq[$] = '{1, 2, 3, 4, 5, 6};
        int last = 0;
        int mon = 0;
        int mfast = 0;
        num_rinses = 2'd0;
        start = 1'b1;
        for (int cyc = 0; cyc < 4000 && m_state != 6; cyc++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL basic_cycle %0d: got %h required %h", cyc, dut_vec, exp_vec());
            end
            if (int'(state) != last) seq.push_back(int'(state));
            last = int'(state);
            if (motor_on) mon++;
            if (motor_fast) mfast++;
            drive_plant(0);
        end
        checks++;
        if (seq != exp_seq) begin
            errors++;
            $display("FAIL basic_sequence: got %p required %p", seq, exp_seq);
        end
        checks++;
        if (mon !== int'(WASH) || mfast !== int'(SPIN)) begin
            errors++;
            $display("FAIL basic_durations: agitate %0d spin %0d required %0d %0d",
                     mon, mfast, WASH, SPIN);
        end
        repeat (4) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b1 || dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL done_hold: got %h required %h", dut_vec, exp_vec());
            end
        end
        start = 1'b0;
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || done !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL done_to_idle: got %h required %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_rinses();
        int seq[$];
        int rl[$];
        int exp_seq[$] = '{1, 2, 3, 4, 1, 3, 4, 1, 3, 4, 5, 6};
        int exp_rl[$] = '{2, 1, 0};
        int last = 0;
        int last_rl = -1;
        int mon = 0;
        num_rinses = 2'd2;
        start = 1'b1;
        for (int cyc = 0; cyc < 6000 && m_state != 6; cyc++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL rinse_cycle %0d: got %h required %h", cyc, dut_vec, exp_vec());
            end
            if (int'(state) != last) seq.push_back(int'(state));
            last = int'(state);
            if (int'(rinses_left) != last_rl) rl.push_back(int'(rinses_left));
            last_rl = int'(rinses_left);
            if (motor_on) mon++;
            if (cyc == 3) num_rinses = 2'd3;
            drive_plant(0);
        end
        checks++;
        if (seq != exp_seq || rl != exp_rl) begin
            errors++;
            $display("FAIL rinse_sequence: got %p / %p required %p / %p", seq, rl, exp_seq, exp_rl);
        end
        checks++;
        if (mon !== int'(WASH + 2 * RINSE)) begin
            errors++;
            $display("FAIL rinse_agitate_total: got %0d required %0d", mon, WASH + 2 * RINSE);
        end
        run_out();
    endtask

    task automatic test_pause();
        int agi = 0;
        bit paused_once = 0;
        num_rinses = 2'd0;
        start = 1'b1;
        for (int cyc = 0; cyc < 4000 && m_state != 4; cyc++) begin
            @(negedge clk);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL pause_cycle %0d: got %h required %h", cyc, dut_vec, exp_vec());
            end
            if (state == 4'd3) agi++;
            if (m_state == 3 && m_elapsed == 300 && !paused_once) begin
                paused_once = 1;
                pause = 1'b1;
                for (int i = 0; i < 37; i++) begin
                    @(negedge clk);
                    checks++;
                    if (motor_on !== 1'b0 || door_lock !== 1'b1 || state !== 4'd3) begin
                        errors++;
                        $display("FAIL pause_hold %0d: motor_on %b lock %b state %0d required 0 1 3",
                                 i, motor_on, door_lock, state);
                    end
                    if (state == 4'd3) agi++;
                end
                pause = 1'b0;
            end
            drive_plant(0);
        end
        checks++;
        if (agi !== int'(WASH) + 37) begin
            errors++;
            $display("FAIL pause_wash_length: got %0d required %0d", agi, WASH + 37);
        end
        run_out();
    endtask

    task automatic test_door_spin();
        num_rinses = 2'd0;
        start = 1'b1;
        for (int cyc = 0; cyc < 4000 && !(m_state == 5 && m_elapsed == 100); cyc++) begin
            @(negedge clk);
            drive_plant(0);
        end
        door_closed = 1'b0;
        @(negedge clk);
        checks++;
        if ({state, fault, door_lock, drain_valve, motor_fast} !== {4'd7, 4'b1010}
            || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL door_fault: got %h required state 7 fault 1 lock 0 drain 1 (%h)",
                     dut_vec, exp_vec());
        end
        start   = 1'b0;
        drained = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 4'd0 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL fault_to_idle: got %h required %h", dut_vec, exp_vec());
        end
        door_closed = 1'b1;
        drained     = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        hold_drain = 1;
        num_rinses = 2'd1;
        start = 1'b1;
        for (int cyc = 0; cyc < 4000 && m_state != 4; cyc++) begin
            @(negedge clk);
            drive_plant(0);
        end
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        checks++;
        if (dut_vec !== 15'd0 || exp_vec() !== 15'd0) begin
            errors++;
            $display("FAIL async_reset: got %h required %h", dut_vec, 15'd0);
        end
        @(negedge clk);
        hold_drain = 0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 4'd1 || fill_valve !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL restart_fill: got %h required %h", dut_vec, exp_vec());
        end
        drive_plant(0);
        @(negedge clk);
        checks++;
        if (state !== 4'd2 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL restart_wash_phase: got %h required %h", dut_vec, exp_vec());
        end
        run_out();
    endtask

    task automatic test_random();
        for (int p = 0; p < 4; p++) begin
            bit fin = 0;
            num_rinses  = RINSE_W'($urandom_range(0, 3));
            start       = 1'b1;
            door_closed = 1'b1;
            pause       = 1'b0;
            for (int cyc = 0; cyc < 9000 && !fin; cyc++) begin
                @(negedge clk);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++;
                    $display("FAIL random_%0d cycle %0d: got %h required %h",
                             p, cyc, dut_vec, exp_vec());
                end
                if (cyc > 0 && m_state == 0) fin = 1;
                if (m_state == 6 || m_state == 7) start = 1'b0;
                if ($urandom_range(0, 199) == 0) num_rinses = RINSE_W'($urandom_range(0, 3));
                if (m_state >= 1 && m_state <= 5) begin
                    if (pause) pause = ($urandom_range(0, 4) != 0);
                    else       pause = ($urandom_range(0, 49) == 0);
                    if ($urandom_range(0, 1499) == 0) door_closed = 1'b0;
                end else begin
                    pause       = 1'b0;
                    door_closed = 1'b1;
                end
                drive_plant(1);
            end
            checks++;
            if (!fin) begin
                errors++;
                $display("FAIL random_%0d timeout: state %0d required 0", p, state);
            end
        end
    endtask

    initial begin
        rst          = 1'b0;
        start        = 1'b0;
        door_closed  = 1'b1;
        filled       = 1'b0;
        drained      = 1'b0;
        detergent_ok = 1'b0;
        pause        = 1'b0;
        num_rinses   = '0;
        test_reset();
        test_door_idle();
        test_basic();
        test_rinses();
        test_pause();
        test_door_spin();
        test_reset_mid_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
